// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one non-pipelined 32x32->32 multiplier
// among N requesters, with a watchdog that aborts a hung multiply.
module mul_share_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [32*N-1:0] p0,
  input  logic [32*N-1:0] p1,
  output logic [N-1:0]    ack,
  output logic            err,
  output logic [31:0]     out,
  output logic            busy,
  output logic            mul_req,
  output logic [31:0]     mul_p0,
  output logic [31:0]     mul_p1,
  input  logic            mul_ack,
  input  logic [31:0]     mul_out
);

  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] LAST_IDX = GW'(N - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [GW-1:0]      last_grant_q;
  logic [GW-1:0]      g_q;
  logic [TW-1:0]      timer_q;
  logic [N-1:0]       ack_q;
  logic               err_q;
  logic               busy_q;
  logic               mul_req_q;
  logic [31:0]        out_q;
  logic [31:0]        mul_p0_q;
  logic [31:0]        mul_p1_q;

  logic [N-1:0][31:0] p0_a;
  logic [N-1:0][31:0] p1_a;
  logic [GW-1:0]      cand_c;
  logic [GW-1:0]      pick_c;

  assign p0_a = p0;
  assign p1_a = p1;

  // Scan from lowest to highest priority so the last hit (closest after
  // last_grant) wins.
  always_comb begin
    cand_c = '0;
    pick_c = '0;
    for (int off = int'(N); off >= 1; off--) begin
      cand_c = GW'((int'(last_grant_q) + off) % int'(N));
      if (req[cand_c]) pick_c = cand_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_IDX;
      g_q          <= '0;
      timer_q      <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mul_req_q    <= 1'b0;
      out_q        <= '0;
      mul_p0_q     <= '0;
      mul_p1_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            g_q       <= pick_c;
            mul_p0_q  <= p0_a[pick_c];
            mul_p1_q  <= p1_a[pick_c];
            mul_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_req_q <= 1'b0;
          timer_q   <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the expiry cycle still counts as a real result.
          if (mul_ack) begin
            out_q   <= mul_out;
            ack_q   <= N'(1) << g_q;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (timer_q == TMAX) begin
            out_q   <= '0;
            ack_q   <= N'(1) << g_q;
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RESP: begin
          ack_q        <= '0;
          err_q        <= 1'b0;
          busy_q       <= 1'b0;
          last_grant_q <= g_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign out     = out_q;
  assign busy    = busy_q;
  assign mul_req = mul_req_q;
  assign mul_p0  = mul_p0_q;
  assign mul_p1  = mul_p1_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: behavioural multiplier with
// programmable latency, per-job scoreboard checked whenever ack pulses.
module tb_mul_share_arb;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0][31:0]  p0_a;
  logic [N-1:0][31:0]  p1_a;
  logic [N-1:0]        ack;
  logic                err;
  logic [31:0]         out;
  logic                busy;
  logic                mul_req;
  logic [31:0]         mul_p0;
  logic [31:0]         mul_p1;
  logic                mul_ack;
  logic [31:0]         mul_out;

  always #5 clk = ~clk;

  mul_share_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .p0      (p0_a),
    .p1      (p1_a),
    .ack     (ack),
    .err     (err),
    .out     (out),
    .busy    (busy),
    .mul_req (mul_req),
    .mul_p0  (mul_p0),
    .mul_p1  (mul_p1),
    .mul_ack (mul_ack),
    .mul_out (mul_out)
  );

  // Multiplier model: completion pulse 'lat' cycles after the start pulse.
  int          lat;
  logic        dead;
  int          mcnt;
  logic [31:0] prod;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0;
      prod <= 32'd0;
    end else if (mul_req) begin
      mcnt <= lat;
      prod <= mul_p0 * mul_p1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign mul_ack = (mcnt == 1) && !dead;
  assign mul_out = (mcnt == 1) ? prod : 32'hDEAD_BEEF;

  typedef struct {
    int          id;
    logic [31:0] y;
    logic        e;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  exp_t sb[$];
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   mreq_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: sample at the falling edge, score any ack, requester drops req.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (mul_req) mreq_cnt++;
    if (ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_onehot", 32'(ack), 32'(1) << e.id);
        check("out", out, e.y);
        check("err", 32'(err), 32'(e.e));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("mul_p0_hold", mul_p0, e.a);
        check("mul_p1_hold", mul_p1, e.b);
      end
      req = req & ~ack;
    end
  endtask

  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b);
    p0_a[2'(id)] = a;
    p1_a[2'(id)] = b;
    req[2'(id)]  = 1'b1;
  endtask

  task automatic push(input int id, input logic [31:0] y, input logic e, input int c,
                      input logic [31:0] a, input logic [31:0] b);
    sb.push_back('{id: id, y: y, e: e, cyc: c, a: a, b: b});
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy || req != '0) && k < budget) begin
      tick();
      k++;
    end
    n_chk++;
    if (sb.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL wait_idle: %0d results outstanding, busy=%0b after %0d cycles",
               sb.size(), busy, k);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl[6];
    int   t0;

    tbl[0] = '{id: 0, a: 32'h0001_0002, b: 32'h0003_0004, y: 32'h000A_0008};
    tbl[1] = '{id: 1, a: 32'hFFFF_FFFF, b: 32'h0000_0002, y: 32'hFFFF_FFFE};
    tbl[2] = '{id: 2, a: 32'h0001_0000, b: 32'h0001_0000, y: 32'h0000_0000};
    tbl[3] = '{id: 3, a: 32'd7,         b: 32'd6,         y: 32'h0000_002A};
    tbl[4] = '{id: 1, a: 32'h8000_0000, b: 32'd3,         y: 32'h8000_0000};
    tbl[5] = '{id: 2, a: 32'h1234_5678, b: 32'd1,         y: 32'h1234_5678};

    n_chk = 0; n_fail = 0; cyc = 0; mreq_cnt = 0;
    lat = 4; dead = 1'b0;
    req = '0;
    p0_a = '0;
    p1_a = '0;

    // Reset values
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_req", 32'(mul_req), 32'd0);
    check("rst_mul_p0", mul_p0, 32'd0);
    check("rst_mul_p1", mul_p1, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Round-robin fairness from reset: order 0,1,2,3, seven cycles apart
    for (int i = 0; i < 4; i++) begin
      p0_a[2'(i)] = 32'(i + 1);
      p1_a[2'(i)] = 32'd10;
    end
    req = 4'b1111;
    t0 = cyc;
    for (int i = 0; i < 4; i++)
      push(i, 32'((i + 1) * 10), 1'b0, t0 + 6 + 7 * i, 32'(i + 1), 32'd10);
    wait_idle(80);

    // Single-requester vectors; operands scrambled after grant must not matter
    for (int i = 0; i < 6; i++) begin
      mreq_cnt = 0;
      drive(tbl[i].id, tbl[i].a, tbl[i].b);
      push(tbl[i].id, tbl[i].y, 1'b0, cyc + 6, tbl[i].a, tbl[i].b);
      tick();
      p0_a[2'(tbl[i].id)] = ~tbl[i].a;
      p1_a[2'(tbl[i].id)] = 32'h5A5A_5A5A;
      wait_idle(40);
      check("mul_req_pulses", 32'(mreq_cnt), 32'd1);
    end

    // Rotation: requester 2 served last, req=0101 -> 0 then 2
    p0_a[0] = 32'd3; p1_a[0] = 32'd3;
    p0_a[2] = 32'd4; p1_a[2] = 32'd5;
    req = 4'b0101;
    t0 = cyc;
    push(0, 32'd9,  1'b0, t0 + 6,  32'd3, 32'd3);
    push(2, 32'd20, 1'b0, t0 + 13, 32'd4, 32'd5);
    wait_idle(40);

    // Timeout: multiplier never completes
    dead = 1'b1;
    drive(1, 32'd5, 32'd5);
    push(1, 32'd0, 1'b1, cyc + 2 + TIMEOUT, 32'd5, 32'd5);
    wait_idle(60);
    dead = 1'b0;

    // Normal service right after a timeout
    drive(3, 32'd3, 32'd4);
    push(3, 32'd12, 1'b0, cyc + 6, 32'd3, 32'd4);
    wait_idle(40);

    // Completion in the expiry cycle wins over the timeout
    lat = TIMEOUT;
    drive(0, 32'd100, 32'd200);
    push(0, 32'd20000, 1'b0, cyc + 2 + TIMEOUT, 32'd100, 32'd200);
    wait_idle(60);

    // Completion one cycle late lands in RESP and is ignored
    lat = TIMEOUT + 1;
    drive(2, 32'd6, 32'd7);
    push(2, 32'd0, 1'b1, cyc + 2 + TIMEOUT, 32'd6, 32'd7);
    wait_idle(60);
    lat = 4;
    tick();
    tick();

    // Async reset in WAIT abandons the job; held request is served afterwards
    drive(1, 32'd9, 32'd9);
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mul_req", 32'(mul_req), 32'd0);
    check("midrst_mul_p0", mul_p0, 32'd0);
    check("midrst_mul_p1", mul_p1, 32'd0);
    check("midrst_out", out, 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    push(1, 32'd81, 1'b0, cyc + 6, 32'd9, 32'd9);
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
